// File: rtl/wb_dma_arb_pkg.sv
// wb_dma_arb_pkg: shared FSM type, priority-mode codes and the
// raw-to-effective priority mapping for the DMA channel arbiter.
package wb_dma_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ARB,
    ARB_GRANT,
    ARB_BUSY
  } arb_state_e;

  localparam logic [1:0] PRI_2LVL = 2'd0;
  localparam logic [1:0] PRI_4LVL = 2'd1;
  localparam logic [1:0] PRI_8LVL = 2'd2;

  // 2 levels: any non-zero raw value is "high".
  // 4 levels: raw values above 2 saturate at 3.
  function automatic logic [2:0] eff_pri(
    input logic [2:0] raw,
    input logic [1:0] mode
  );
    logic [2:0] p;
    p = raw;
    unique case (1'b1)
      (mode == PRI_2LVL): p = {2'b00, |raw};
      (mode == PRI_4LVL): p = (raw > 3'd2) ? 3'd3 : raw;
      default:            p = raw;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/wb_dma_pri_lvl_map.sv
// wb_dma_pri_lvl_map: one channel's eligibility and effective priority.
// Ports: req_i/raw_i in; vld_o (eligible), pri_o (0 when not eligible).
module wb_dma_pri_lvl_map
  import wb_dma_arb_pkg::*;
#(
  parameter logic [1:0] PRI_SEL = PRI_2LVL,
  parameter logic       PRESENT = 1'b1
) (
  input  logic       req_i,
  input  logic [2:0] raw_i,
  output logic       vld_o,
  output logic [2:0] pri_o
);

  assign vld_o = req_i & PRESENT;
  assign pri_o = vld_o ? eff_pri(raw_i, PRI_SEL) : 3'd0;

endmodule

// File: rtl/wb_dma_pri_arb.sv
// wb_dma_pri_arb: registered priority arbiter, round-robin within a level.
// Ports: req_i/pri_i/ack_i/done_i in; gnt_vld/ch/oh/pri and busy out.
module wb_dma_pri_arb
  import wb_dma_arb_pkg::*;
#(
  parameter int              CH_NUM  = 8,
  parameter int              CH_W    = 3,
  parameter logic [CH_NUM-1:0] CH_CONF = {CH_NUM{1'b1}},
  parameter logic [1:0]      PRI_SEL = PRI_2LVL
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [CH_NUM-1:0]   req_i,
  input  logic [3*CH_NUM-1:0] pri_i,
  input  logic                ack_i,
  input  logic                done_i,
  output logic                gnt_vld_o,
  output logic [CH_W-1:0]     gnt_ch_o,
  output logic [CH_NUM-1:0]   gnt_oh_o,
  output logic [2:0]          gnt_pri_o,
  output logic                busy_o
);

  if (PRI_SEL == 2'd3) begin : g_bad_pri
    $error("wb_dma_pri_arb: PRI_SEL=3 is illegal");
  end
  if (CH_NUM < 2 || CH_NUM > 31) begin : g_bad_num
    $error("wb_dma_pri_arb: CH_NUM out of range");
  end
  if ((1 << CH_W) < CH_NUM) begin : g_bad_w
    $error("wb_dma_pri_arb: CH_W too narrow");
  end

  logic [CH_NUM-1:0] elig;
  logic [2:0]        epri [CH_NUM];

  for (genvar k = 0; k < CH_NUM; k++) begin : g_map
    wb_dma_pri_lvl_map #(
      .PRI_SEL(PRI_SEL),
      .PRESENT(CH_CONF[k])
    ) u_map (
      .req_i(req_i[k]),
      .raw_i(pri_i[3*k +: 3]),
      .vld_o(elig[k]),
      .pri_o(epri[k])
    );
  end

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_NUM-1:0] oh_q, oh_d;
  logic [2:0]        pri_q, pri_d;

  logic [2:0]        max_pri;
  logic [CH_NUM-1:0] cand;
  logic              hi_hit;
  logic [CH_W-1:0]   hi_ch, lo_ch, win_ch;
  logic [CH_NUM-1:0] win_oh;

  // Ineligible channels read as priority 0, so a plain max works.
  always_comb begin
    max_pri = 3'd0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (epri[k] > max_pri) max_pri = epri[k];
    end
  end

  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      cand[k] = elig[k] & (epri[k] == max_pri);
    end
  end

  // Circular scan from last+1: lowest candidate above last wins,
  // otherwise wrap to the lowest candidate overall.
  always_comb begin
    hi_hit = 1'b0;
    hi_ch  = '0;
    lo_ch  = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (cand[k]) begin
        lo_ch = CH_W'(k);
        if (CH_W'(k) > last_q) begin
          hi_hit = 1'b1;
          hi_ch  = CH_W'(k);
        end
      end
    end
    win_ch = hi_hit ? hi_ch : lo_ch;
    win_oh = {{(CH_NUM-1){1'b0}}, 1'b1} << win_ch;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ARB_IDLE;
      last_q  <= CH_W'(CH_NUM - 1);
      ch_q    <= '0;
      oh_q    <= '0;
      pri_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ch_q    <= ch_d;
      oh_q    <= oh_d;
      pri_q   <= pri_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ch_d    = ch_q;
    oh_d    = oh_q;
    pri_d   = pri_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|elig) state_d = ARB_ARB;
      end
      ARB_ARB: begin
        if (|elig) begin
          ch_d    = win_ch;
          oh_d    = win_oh;
          pri_d   = max_pri;
          state_d = ARB_GRANT;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (ack_i) begin
          if (done_i) begin
            last_d  = ch_q;
            oh_d    = '0;
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_BUSY;
          end
        end else if (~|(req_i & oh_q)) begin
          oh_d    = '0;
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (done_i) begin
          last_d  = ch_q;
          oh_d    = '0;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign gnt_vld_o = (state_q == ARB_GRANT);
  assign busy_o    = (state_q != ARB_IDLE);
  assign gnt_ch_o  = ch_q;
  assign gnt_oh_o  = oh_q;
  assign gnt_pri_o = pri_q;

endmodule

// File: doc/wb_dma_pri_arb.md
Name: wb_dma_pri_arb

Overview:
Parametrised, registered channel arbiter for the DMA engine. It generalises the per-channel priority encoding to CH_NUM channels and selectable 2/4/8 priority levels, picks the highest-priority eligible requester, and breaks ties round-robin. It holds the grant under a valid/ack/done handshake with the transfer engine. It sits between the channel register file and the DMA engine's channel-select logic.

Parameters:
CH_NUM, 8, number of channels (2..31).
CH_W, 3, grant index width; must be ≥ clog2(CH_NUM).
CH_CONF, {CH_NUM{1'b1}}, per-channel present mask; a cleared bit excludes that channel permanently.
PRI_SEL, 2'd0, priority mode: 0 = 2 levels, 1 = 4 levels, 2 = 8 levels; 3 is illegal and is rejected by an elaboration check.

Ports:
clk_i  in  1  clock; all state changes on the rising edge.
rst_n_i  in  1  asynchronous reset, active low.
req_i  in  CH_NUM  per-channel transfer request (valid).
pri_i  in  3*CH_NUM  packed raw priorities; channel k uses bits [3k+2:3k].
ack_i  in  1  engine accepted the current grant.
done_i  in  1  engine finished the granted transfer.
gnt_vld_o  out  1  grant offered.
gnt_ch_o  out  CH_W  granted channel index.
gnt_oh_o  out  CH_NUM  granted channel, one-hot.
gnt_pri_o  out  3  effective priority of the winner.
busy_o  out  1  high in the ARB, GRANT and BUSY states.

Behaviour:
- Eligible channel k: req_i[k] & CH_CONF[k].
- Effective priority per mode:
  - mode 0: 0 if raw == 0, else 1.
  - mode 1: raw if raw ≤ 2, else 3 (saturate).
  - mode 2: raw.
- FSM states: IDLE, ARB, GRANT, BUSY.
- IDLE: any eligible channel → ARB next cycle.
- ARB (one cycle):
  - Sample req_i/pri_i and find the maximum effective priority P among eligible channels.
  - Winner = first eligible channel with priority P, scanning circularly from last_ch+1.
  - Register gnt_ch_o, gnt_oh_o and gnt_pri_o; go to GRANT.
  - If no eligible channel remains, return to IDLE with outputs unchanged.
- GRANT:
  - gnt_vld_o = 1.
  - ack_i → BUSY.
  - ack_i & done_i in the same cycle → IDLE, last_ch ← gnt_ch_o.
  - No ack_i and req_i[gnt_ch_o] = 0 (retraction) → IDLE, last_ch unchanged, gnt_oh_o cleared.
  - ack_i takes precedence over retraction.
- BUSY:
  - gnt_vld_o = 0; gnt_ch_o/gnt_oh_o/gnt_pri_o held.
  - done_i → IDLE, last_ch ← gnt_ch_o, gnt_oh_o cleared next cycle.
  - req_i changes are ignored in BUSY.
- done_i outside GRANT/BUSY is ignored; ack_i outside GRANT is ignored.
- Latency: request in IDLE at cycle t → gnt_vld_o high at t+2. After done_i, re-arbitration is IDLE→ARB, so there are at least 2 cycles between grants.
- gnt_vld_o is asserted only in GRANT (Moore output).
- Round robin: after channel CH_NUM-1 the scan wraps to 0. Lower-priority channels may starve by design; fairness applies only within a priority level.
- Reset (asynchronous, immediate, any state):
  - state = IDLE, last_ch = CH_NUM-1 (channel 0 scanned first).
  - gnt_vld_o = 0, gnt_ch_o = 0, gnt_oh_o = 0, gnt_pri_o = 0, busy_o = 0.
- Release of rst_n_i is synchronised externally.

Decomposition:
- Shared package wb_dma_arb_pkg:
  - FSM state enum.
  - PRI_SEL mode constants (PRI_2LVL = 0, PRI_4LVL = 1, PRI_8LVL = 2).
  - Function eff_pri(raw, mode).
- One combinational sub-module, wb_dma_pri_lvl_map: per-channel raw → effective priority with valid masking, instantiated CH_NUM times by generate.
- Max-find, circular scan and FSM live in the top module.

Test Plan:
1. Reset: assert rst_n_i mid-BUSY → all outputs 0 in the same cycle; after release with req_i = 0 → state stays IDLE, busy_o = 0.
2. PRI_SEL = 2; ch2 pri 5, ch6 pri 7 requesting at t → gnt_vld_o = 1 at t+2, gnt_ch_o = 6, gnt_oh_o = 8'h40, gnt_pri_o = 7.
3. PRI_SEL = 0; ch1 pri 3 and ch4 pri 1 (both effective 1), held with ack/done cycling → grant order ch1, ch4, ch1.
4. PRI_SEL = 1; ch0 pri 6, ch3 pri 3 → both effective 3, tie → ch0 first, gnt_pri_o = 3.
5. Retraction: ch3 granted, req_i[3] drops in GRANT without ack → gnt_vld_o = 0 next cycle; ch3 wins again on re-request (last_ch unchanged).
6. CH_CONF = 8'hDF; ch5 pri 7 and ch0 pri 0 requesting → ch0 granted; ch5 never granted.
